lcd_pixel_pump: RTL and testbench

Pixel-stage consumer placed directly downstream of the HV-mode timing generator. Buffers a pixel stream from an upstream source in a small FIFO, aligns it to frame boundaries using a start-of-frame marker, and drives one pixel onto the panel RGB bus on every cycle the timing generator asserts `data_en`. It detects and reports starvation (underflow), stream misalignment and dropped frames, then recovers automatically at the next frame.

---
 rtl/lcd_pixel_pump_if.sv | 12 +
 rtl/lcd_pixel_pump.sv | 140 ++++++++++++++
 tb/tb_lcd_pixel_pump.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_pixel_pump_if.sv
// Upstream pixel stream: valid/ready handshake carrying a pixel and its start-of-frame flag.
interface lcd_pixel_pump_if #(
    parameter int unsigned DATA_WIDTH = 24
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_sof;

    modport master (output in_valid, in_data, in_sof, input in_ready);
    modport slave  (input in_valid, in_data, in_sof, output in_ready);
endinterface

// File: rtl/lcd_pixel_pump.sv
// Panel pixel pump: buffers an upstream pixel stream, aligns it to frame boundaries
// and drives one pixel per data_en cycle, reporting starvation, misalignment and drops.
module lcd_pixel_pump #(
    parameter int unsigned           DATA_WIDTH = 24,
    parameter int unsigned           DEPTH      = 16,
    parameter int unsigned           H_ACTIVE   = 1024,
    parameter int unsigned           V_ACTIVE   = 600,
    parameter logic [DATA_WIDTH-1:0] IDLE_COLOR = '0
) (
    input  logic                  clock,
    input  logic                  reset_L,
    input  logic                  en,
    lcd_pixel_pump_if.slave       pix,
    input  logic                  frame_start,
    input  logic                  data_en,
    output logic [DATA_WIDTH-1:0] rgb,
    output logic                  rgb_de,
    output logic                  underflow,
    output logic                  misalign,
    output logic                  frame_drop,
    output logic [$clog2(DEPTH):0] level
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int unsigned YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

    typedef enum logic [1:0] {ALIGN, ARMED, STREAM} state_t;

    logic [DATA_WIDTH:0]   mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  ready_q;
    logic                  empty;
    logic                  head_sof;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  push;
    logic                  pop;

    state_t                state;
    logic                  starved;
    logic [XW-1:0]         x;
    logic [YW-1:0]         y;
    logic                  stream_cyc;
    logic                  at_origin;
    logic                  mid_sof;
    logic                  pop_stream;
    logic                  underflow_c;
    logic                  misalign_c;

    assign empty        = (level == '0);
    assign head_sof     = mem[rd_ptr][DATA_WIDTH];
    assign head_data    = mem[rd_ptr][DATA_WIDTH-1:0];
    assign pix.in_ready = ready_q && (level != LW'(DEPTH));
    assign push         = pix.in_valid && pix.in_ready;

    assign stream_cyc  = en && (state == STREAM) && data_en;
    assign at_origin   = (x == '0) && (y == '0);
    assign mid_sof     = head_sof && !at_origin;
    assign underflow_c = stream_cyc && empty;
    // A mid-frame sof is reported once; later cycles of the frame are plain starved idles.
    assign misalign_c  = stream_cyc && !empty && mid_sof && !starved;
    assign pop_stream  = stream_cyc && !empty && !mid_sof && !starved;
    assign pop         = (en && (state == ALIGN) && !empty && !head_sof) || pop_stream;

    // Storage array, no reset needed: occupancy is tracked by the pointers.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= {pix.in_sof, pix.in_data};
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            level <= level + LW'(push) - LW'(pop);
        end
    end

    // Frame FSM, raster position and registered panel outputs.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state      <= ALIGN;
            starved    <= 1'b0;
            x          <= '0;
            y          <= '0;
            rgb        <= '0;
            rgb_de     <= 1'b0;
            underflow  <= 1'b0;
            misalign   <= 1'b0;
            frame_drop <= 1'b0;
        end else begin
            rgb_de     <= data_en;
            rgb        <= pop_stream ? head_data : IDLE_COLOR;
            underflow  <= underflow_c;
            misalign   <= misalign_c;
            frame_drop <= en && frame_start && (state != ARMED);
            if (en) begin
                case (state)
                    ALIGN: begin
                        if (!empty && head_sof) state <= ARMED;
                    end
                    ARMED: begin
                        if (frame_start) begin
                            x     <= '0;
                            y     <= '0;
                            state <= STREAM;
                        end
                    end
                    STREAM: begin
                        if (data_en) begin
                            if (underflow_c || misalign_c) starved <= 1'b1;
                            if (x == X_LAST) begin
                                x <= '0;
                                if (y == Y_LAST) begin
                                    y       <= '0;
                                    starved <= 1'b0;
                                    state   <= ALIGN;
                                end else begin
                                    y <= y + YW'(1);
                                end
                            end else begin
                                x <= x + XW'(1);
                            end
                        end
                    end
                    default: state <= ALIGN;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_lcd_pixel_pump.sv
// Scoreboard bench for lcd_pixel_pump: a queue-based frame model predicts each panel
// pixel; a negedge monitor pops and compares whenever rgb_de is presented.
module tb_lcd_pixel_pump;
    localparam int unsigned DW    = 24;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned H     = 4;
    localparam int unsigned V     = 2;
    localparam logic [DW-1:0] IDLE = '0;
    localparam int P_ALIGN  = 0;
    localparam int P_ARMED  = 1;
    localparam int P_STREAM = 2;

    typedef struct packed { logic sof; logic [DW-1:0] data; } pix_t;
    typedef struct packed { logic [DW-1:0] rgb; logic uf; logic ma; } exp_t;

    logic          clock = 1'b0;
    logic          reset_L = 1'b0;
    logic          en = 1'b1;
    logic          frame_start = 1'b0;
    logic          data_en = 1'b0;
    logic [DW-1:0] rgb;
    logic          rgb_de, underflow, misalign, frame_drop;
    logic [2:0]    level;

    lcd_pixel_pump_if #(.DATA_WIDTH(DW)) pix ();

    lcd_pixel_pump #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .H_ACTIVE(H), .V_ACTIVE(V), .IDLE_COLOR(IDLE)
    ) dut (
        .clock(clock), .reset_L(reset_L), .en(en), .pix(pix),
        .frame_start(frame_start), .data_en(data_en), .rgb(rgb), .rgb_de(rgb_de),
        .underflow(underflow), .misalign(misalign), .frame_drop(frame_drop), .level(level)
    );

    always #5 clock = ~clock;

    int   errors = 0;
    int   checks = 0;
    int   uf_seen = 0;
    int   ma_seen = 0;
    int   fd_seen = 0;
    int   vprob = 100;
    bit   rand_en = 1'b0;

    pix_t mq[$];
    pix_t src[$];
    exp_t sb[$];
    int   m_phase = P_ALIGN;
    int   m_pos = 0;
    bit   m_starved = 1'b0;
    bit   m_ready_ok = 1'b0;
    bit   m_fd = 1'b0;
    exp_t mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame model: linear position within the frame, FIFO as a queue.
    task automatic model_step();
        bit   push;
        exp_t e;
        pix_t h;
        push = pix.in_valid && m_ready_ok && (mq.size() < DEPTH);
        e = '{rgb: IDLE, uf: 1'b0, ma: 1'b0};
        m_fd = en && frame_start && (m_phase != P_ARMED);
        if (en) begin
            if (m_phase == P_ALIGN) begin
                if (mq.size() > 0) begin
                    if (mq[0].sof) m_phase = P_ARMED;
                    else h = mq.pop_front();
                end
            end else if (m_phase == P_ARMED) begin
                if (frame_start) begin
                    m_pos = 0;
                    m_phase = P_STREAM;
                end
            end else if (data_en) begin
                if (mq.size() == 0) begin
                    e.uf = 1'b1;
                    m_starved = 1'b1;
                end else if (mq[0].sof && m_pos != 0) begin
                    if (!m_starved) e.ma = 1'b1;
                    m_starved = 1'b1;
                end else if (!m_starved) begin
                    h = mq.pop_front();
                    e.rgb = h.data;
                end
                m_pos++;
                if (m_pos == int'(H * V)) begin
                    m_phase = P_ALIGN;
                    m_starved = 1'b0;
                end
            end
        end
        if (data_en) sb.push_back(e);
        if (push) begin
            mq.push_back('{sof: pix.in_sof, data: pix.in_data});
            h = src.pop_front();
        end
        m_ready_ok = 1'b1;
    endtask

    task automatic tick(input bit fs, input bit de);
        frame_start = fs;
        data_en = de;
        en = rand_en ? ($urandom_range(9) != 0) : 1'b1;
        if (src.size() > 0 && $urandom_range(99) < vprob) begin
            pix.in_valid = 1'b1;
            pix.in_sof = src[0].sof;
            pix.in_data = src[0].data;
        end else begin
            pix.in_valid = 1'b0;
            pix.in_sof = 1'b0;
            pix.in_data = DW'($urandom);
        end
        model_step();
        @(negedge clock);
        check("level", 32'(level), 32'(mq.size()));
        check("in_ready", 32'(pix.in_ready), 32'(m_ready_ok && (mq.size() < DEPTH)));
        check("frame_drop", 32'(frame_drop), 32'(m_fd));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
    endtask

    task automatic add_px(input bit sof, input logic [DW-1:0] d);
        src.push_back('{sof: sof, data: d});
    endtask

    task automatic frame(input int gap_max, input bit spurious);
        tick(1'b1, 1'b0);
        idle(2);
        for (int ln = 0; ln < int'(V); ln++) begin
            for (int px = 0; px < int'(H); px++) begin
                tick(1'b0, 1'b1);
                idle($urandom_range(gap_max));
            end
            if (spurious && ln == 0) tick(1'b1, 1'b0);
            idle(1);
        end
    endtask

    task automatic do_reset(input bit de);
        #2;
        reset_L = 1'b0;
        frame_start = 1'b0;
        data_en = de;
        en = 1'b1;
        pix.in_valid = 1'b0;
        pix.in_sof = 1'b0;
        pix.in_data = '0;
        sb.delete();
        mq.delete();
        src.delete();
        m_phase = P_ALIGN;
        m_pos = 0;
        m_starved = 1'b0;
        m_ready_ok = 1'b0;
        m_fd = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_rgb", 32'(rgb), 32'h0);
        check("rst_rgb_de", 32'(rgb_de), 32'h0);
        check("rst_underflow", 32'(underflow), 32'h0);
        check("rst_misalign", 32'(misalign), 32'h0);
        check("rst_frame_drop", 32'(frame_drop), 32'h0);
        check("rst_level", 32'(level), 32'h0);
        check("rst_in_ready", 32'(pix.in_ready), 32'h0);
        data_en = 1'b0;
        reset_L = 1'b1;
    endtask

    // Scoreboard monitor: one expected entry per presented panel cycle.
    always @(negedge clock) begin
        if (reset_L) begin
            if (underflow) uf_seen++;
            if (misalign) ma_seen++;
            if (frame_drop) fd_seen++;
            if (rgb_de) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard: rgb_de with no expected pixel at %0t", $time);
                end else begin
                    mon_e = sb.pop_front();
                    check("rgb", 32'(rgb), 32'(mon_e.rgb));
                    check("underflow", 32'(underflow), 32'(mon_e.uf));
                    check("misalign", 32'(misalign), 32'(mon_e.ma));
                end
            end else begin
                check("idle_underflow", 32'(underflow), 32'h0);
                check("idle_misalign", 32'(misalign), 32'h0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        int n;
        pix.in_valid = 1'b0;
        pix.in_sof = 1'b0;
        pix.in_data = '0;

        // Reset release with data_en held high.
        do_reset(1'b1);
        tick(1'b0, 1'b0);
        check("post_rst_in_ready", 32'(pix.in_ready), 32'h1);
        check("post_rst_rgb", 32'(rgb), 32'h0);

        // Nominal frame 1..8.
        for (int i = 1; i <= 8; i++) add_px(i == 1, DW'(i));
        idle(6);
        base = uf_seen + ma_seen;
        frame(0, 1'b0);
        idle(4);
        check("nominal_no_errors", 32'(uf_seen + ma_seen - base), 32'h0);

        // Alignment: leading non-sof pixels are discarded.
        add_px(1'b0, 24'hAA);
        add_px(1'b0, 24'hBB);
        for (int i = 1; i <= 8; i++) add_px(i == 1, DW'(i));
        idle(8);
        frame(1, 1'b0);
        idle(3);

        // Underflow: 5 pixels for an 8-pixel frame, then a clean frame.
        for (int i = 0; i < 5; i++) add_px(i == 0, DW'($urandom));
        idle(8);
        base = uf_seen;
        frame(0, 1'b0);
        idle(3);
        check("underflow_count", 32'(uf_seen - base), 32'h3);
        for (int i = 0; i < 8; i++) add_px(i == 0, DW'($urandom));
        idle(6);
        frame(0, 1'b0);
        idle(3);

        // Misalign: sof pixel at (2,0); it starts the next frame.
        add_px(1'b1, 24'h000101);
        add_px(1'b0, 24'h000102);
        for (int i = 0; i < 8; i++) add_px(i == 0, 24'h000200 + DW'(i));
        idle(6);
        base = ma_seen;
        frame(0, 1'b0);
        idle(3);
        check("misalign_count", 32'(ma_seen - base), 32'h1);
        frame(0, 1'b0);
        idle(3);

        // Reset in the middle of a streamed frame, then recover.
        for (int i = 0; i < 8; i++) add_px(i == 0, DW'($urandom));
        idle(6);
        tick(1'b1, 1'b0);
        idle(2);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
        do_reset(1'b0);
        for (int i = 0; i < 8; i++) add_px(i == 0, DW'($urandom));
        idle(6);
        frame(0, 1'b0);
        idle(3);

        // Backpressure and frame drop.
        for (int i = 0; i < 5; i++) add_px(i == 0, DW'($urandom));
        idle(7);
        check("full_level", 32'(level), 32'h4);
        check("full_in_ready", 32'(pix.in_ready), 32'h0);
        base = fd_seen;
        tick(1'b1, 1'b0);
        idle(1);
        tick(1'b1, 1'b0);
        idle(2);
        check("frame_drop_count", 32'(fd_seen - base), 32'h1);
        for (int i = 0; i < int'(H * V); i++) tick(1'b0, 1'b1);
        idle(4);

        // Randomized frames: irregular feed, stray sof, en gaps, extra frame_start.
        rand_en = 1'b1;
        for (int f = 0; f < 25; f++) begin
            n = int'(H * V);
            case ($urandom_range(9))
                0: n = n - 1;
                1: n = n + 1;
                default: ;
            endcase
            vprob = int'($urandom_range(60, 100));
            for (int i = 0; i < n; i++) add_px((i == 0) || ($urandom_range(29) == 0), DW'($urandom));
            idle(int'($urandom_range(1, 6)));
            frame(int'($urandom_range(2)), $urandom_range(4) == 0);
            idle(int'($urandom_range(0, 4)));
        end
        rand_en = 1'b0;
        vprob = 100;
        idle(4);

        check("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
